// File: rtl/bp_stat_ctrl.sv
// bp_stat_ctrl: branch-predictor statistics controller.
// Counts cycles, retired (non-bubble) fetches, branches and mispredicts over a
// measurement run bounded by stop_i, a halt instruction or an optional cycle
// window. Counters saturate and raise a sticky flag; any counter can be read
// back at any time through a registered one-cycle-latency port.
module bp_stat_ctrl #(
    parameter int          CNT_W     = 32,
    parameter logic [31:0] HALT_INSN = 32'h0000_006F,
    parameter int          WINDOW    = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             br_instr_i,
    input  logic             br_miss_i,
    input  logic [31:0]      instr_i,
    input  logic             rd_en_i,
    input  logic [1:0]       rd_addr_i,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             rd_vld_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             sat_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Canonical RISC-V bubble (addi x0,x0,0) is not counted as an instruction.
    localparam logic [31:0]      NOP_INSN = 32'h0000_0013;
    localparam logic             WIN_EN   = (WINDOW != 0);
    // Cycle-counter value during the last cycle of a windowed run.
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'((WINDOW == 0) ? 0 : WINDOW - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ins_q, ins_d;
    logic [CNT_W-1:0] br_q,  br_d;
    logic [CNT_W-1:0] mis_q, mis_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_vld_q;
    logic [CNT_W-1:0] rd_sel;

    logic [CNT_W:0]   cyc_inc, ins_inc, br_inc, mis_inc;
    logic             run_exit;

    // Saturating increment: returns {attempted-at-max, next value}.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic             en);
        logic [CNT_W:0] res;
        res = {1'b0, val};
        if (en) begin
            if (val == '1) begin
                res = {1'b1, val};
            end else begin
                res = {1'b0, val + CNT_W'(1)};
            end
        end
        return res;
    endfunction

    // Candidate increments and run-termination condition for the current cycle.
    always_comb begin
        cyc_inc  = sat_inc(cyc_q, 1'b1);
        ins_inc  = sat_inc(ins_q, instr_i != NOP_INSN);
        br_inc   = sat_inc(br_q,  br_instr_i);
        mis_inc  = sat_inc(mis_q, br_miss_i);
        run_exit = stop_i || (instr_i == HALT_INSN) || (WIN_EN && (cyc_q == WIN_LAST));
    end

    // Next-state and counter update; start only acts outside RUN.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        br_d    = br_q;
        mis_d   = mis_q;
        sat_d   = sat_q;
        case (state_q)
            S_RUN: begin
                cyc_d = cyc_inc[CNT_W-1:0];
                ins_d = ins_inc[CNT_W-1:0];
                br_d  = br_inc[CNT_W-1:0];
                mis_d = mis_inc[CNT_W-1:0];
                sat_d = sat_q | cyc_inc[CNT_W] | ins_inc[CNT_W]
                              | br_inc[CNT_W]  | mis_inc[CNT_W];
                if (run_exit) begin
                    state_d = S_DONE;
                end
            end
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    cyc_d   = '0;
                    ins_d   = '0;
                    br_d    = '0;
                    mis_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Readout mux over the pre-edge counter values.
    always_comb begin
        rd_sel = cyc_q;
        case (rd_addr_i)
            2'd0: rd_sel = cyc_q;
            2'd1: rd_sel = ins_q;
            2'd2: rd_sel = br_q;
            2'd3: rd_sel = mis_q;
            default: rd_sel = cyc_q;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            ins_q   <= '0;
            br_q    <= '0;
            mis_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
            br_q    <= br_d;
            mis_q   <= mis_d;
            sat_q   <= sat_d;
        end
    end

    // Registered readout: data captured on request, held otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_vld_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= rd_sel;
            end
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_vld_o  = rd_vld_q;
    assign busy_o    = (state_q == S_RUN);
    assign done_o    = (state_q == S_DONE);
    assign sat_o     = sat_q;

endmodule

// File: tb/tb_bp_stat_ctrl.sv
// Scoreboard bench for bp_stat_ctrl. Three instances share one stimulus stream:
// default build, a 4-bit counter build, and a WINDOW=4 build.
module tb_bp_stat_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_006F;
    localparam logic [31:0] ADDI = 32'h0010_0093;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0, stop_i = 1'b0, br_instr_i = 1'b0, br_miss_i = 1'b0;
    logic [31:0] instr_i = NOP;
    logic        rd_en_i = 1'b0;
    logic [1:0]  rd_addr_i = 2'd0;

    logic [31:0] rdd0, rdd2;
    logic [3:0]  rdd1;
    logic [2:0]  vld, busy, done, sat;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: per instance a phase (0 idle, 1 run, 2 done), four counters, sticky flag.
    longint mx[3]  = '{64'hFFFF_FFFF, 64'hF, 64'hFFFF_FFFF};
    longint win[3] = '{0, 0, 4};
    int     ph[3]  = '{0, 0, 0};
    longint cnt[3][4];
    bit     msat[3] = '{0, 0, 0};
    longint q[3][$];

    always #5 clk = ~clk;

    bp_stat_ctrl u_main (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .br_instr_i(br_instr_i), .br_miss_i(br_miss_i), .instr_i(instr_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rdd0),
        .rd_vld_o(vld[0]), .busy_o(busy[0]), .done_o(done[0]), .sat_o(sat[0])
    );

    bp_stat_ctrl #(.CNT_W(4)) u_sat (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .br_instr_i(br_instr_i), .br_miss_i(br_miss_i), .instr_i(instr_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rdd1),
        .rd_vld_o(vld[1]), .busy_o(busy[1]), .done_o(done[1]), .sat_o(sat[1])
    );

    bp_stat_ctrl #(.WINDOW(4)) u_win (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .br_instr_i(br_instr_i), .br_miss_i(br_miss_i), .instr_i(instr_i),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rdd2),
        .rd_vld_o(vld[2]), .busy_o(busy[2]), .done_o(done[2]), .sat_o(sat[2])
    );

    function automatic longint act_data(input int k);
        if (k == 0) return longint'(rdd0);
        if (k == 1) return longint'(rdd1);
        return longint'(rdd2);
    endfunction

    task automatic chk(input string name, input int k, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
        end
    endtask

    // Reference model: follows the run rules at each clock edge, reset wins.
    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 3; k++) begin
                ph[k] = 0;
                msat[k] = 0;
                for (int i = 0; i < 4; i++) cnt[k][i] = 0;
                q[k].delete();
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit     ev[4];
                longint cyc_before;
                if (rd_en_i) q[k].push_back(cnt[k][rd_addr_i]);
                if (ph[k] == 1) begin
                    ev[0] = 1'b1;
                    ev[1] = (instr_i != NOP);
                    ev[2] = br_instr_i;
                    ev[3] = br_miss_i;
                    cyc_before = cnt[k][0];
                    for (int i = 0; i < 4; i++) begin
                        if (ev[i]) begin
                            if (cnt[k][i] == mx[k]) msat[k] = 1;
                            else cnt[k][i] = cnt[k][i] + 1;
                        end
                    end
                    if (stop_i || instr_i == HALT || (win[k] != 0 && cyc_before == win[k] - 1))
                        ph[k] = 2;
                end else if (start_i) begin
                    for (int i = 0; i < 4; i++) cnt[k][i] = 0;
                    msat[k] = 0;
                    ph[k] = 1;
                end
            end
        end
    end

    // Monitor: status every cycle, readout whenever the DUT presents a result.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk("busy", k, longint'(busy[k]), longint'(ph[k] == 1));
            chk("done", k, longint'(done[k]), longint'(ph[k] == 2));
            chk("sat",  k, longint'(sat[k]),  longint'(msat[k]));
            if (vld[k]) begin
                if (q[k].size() == 0) begin
                    chk("rd_vld_unexpected", k, 1, 0);
                end else begin
                    chk("rd_data", k, act_data(k), q[k].pop_front());
                end
            end else if (q[k].size() != 0) begin
                chk("rd_vld_missing", k, 0, 1);
                q[k].delete();
            end
        end
    end

    task automatic drive(input logic st, input logic sp, input logic [31:0] ins,
                         input logic b, input logic m, input logic re, input logic [1:0] a);
        start_i    = st;
        stop_i     = sp;
        instr_i    = ins;
        br_instr_i = b;
        br_miss_i  = m;
        rd_en_i    = re;
        rd_addr_i  = a;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, NOP, 0, 0, 0, 2'd0);
    endtask

    task automatic read_all();
        for (int a = 0; a < 4; a++) drive(0, 0, NOP, 0, 0, 1, 2'(a));
        idle(1);
    endtask

    initial begin
        // Power-on reset.
        rst_i = 1'b1;
        idle(3);
        rst_i = 1'b0;
        idle(2);
        read_all();

        // Basic run: 10 cycles, 7 real instrs, 3 branches, 1 miss, stop on the 10th.
        drive(1, 0, NOP, 0, 0, 0, 2'd0);
        for (int i = 0; i < 10; i++)
            drive(0, i == 9, (i < 7) ? ADDI : NOP, (i == 1 || i == 4 || i == 8),
                  (i == 4), 0, 2'd0);
        idle(2);
        read_all();

        // Halt detect on the 5th run cycle, stop_i never raised.
        drive(1, 0, NOP, 0, 0, 0, 2'd0);
        for (int i = 0; i < 5; i++) drive(0, 0, (i == 4) ? HALT : ADDI, 0, 0, 0, 2'd0);
        idle(3);
        read_all();

        // Saturation / window: 22 branch cycles, then stop; next start clears.
        drive(1, 0, NOP, 0, 0, 0, 2'd0);
        for (int i = 0; i < 22; i++) drive(0, 0, NOP, 1, 0, 0, 2'd0);
        drive(0, 1, NOP, 1, 0, 0, 2'd0);
        read_all();
        drive(1, 0, NOP, 0, 0, 0, 2'd0);
        idle(1);
        drive(0, 1, NOP, 0, 0, 0, 2'd0);
        read_all();

        // Asynchronous reset during the 3rd run cycle.
        drive(1, 0, NOP, 0, 0, 0, 2'd0);
        drive(0, 0, ADDI, 1, 1, 0, 2'd0);
        drive(0, 0, ADDI, 1, 0, 1, 2'd1);
        start_i = 1'b0; instr_i = ADDI; br_instr_i = 1'b1; rd_en_i = 1'b1; rd_addr_i = 2'd0;
        #1 rst_i = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_async_busy", k, longint'(busy[k]), 0);
            chk("rst_async_done", k, longint'(done[k]), 0);
            chk("rst_async_sat",  k, longint'(sat[k]),  0);
            chk("rst_async_vld",  k, longint'(vld[k]),  0);
            chk("rst_async_data", k, act_data(k), 0);
        end
        @(negedge clk);
        #1 rst_i = 1'b0;
        idle(2);
        drive(0, 1, NOP, 0, 0, 0, 2'd0);
        read_all();

        // Read/update collision at cycle count 6, with a mid-run start ignored.
        drive(1, 0, NOP, 0, 0, 0, 2'd0);
        for (int i = 0; i < 6; i++) drive(0, 0, ADDI, 0, 0, 0, 2'd0);
        drive(1, 0, NOP, 0, 0, 1, 2'd0);
        idle(2);
        drive(0, 1, NOP, 0, 0, 0, 2'd0);
        read_all();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [31:0] ins;
            r = int'($urandom_range(0, 99));
            if (r < 25) ins = NOP;
            else if (r < 28) ins = HALT;
            else ins = $urandom;
            drive($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 4, ins,
                  $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_stat_ctrl.md
BP_STAT_CTRL -- requirements
Module: bp_stat_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of every statistics counter and of rd_data_o.
REQ-002 Parameter HALT_INSN, default 32'h0000_006F: fetched encoding that ends a measurement run (jal x0,0 self-loop).
REQ-003 Parameter WINDOW, default 0: run length limit in cycles; 0 = unlimited.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 start_i  input  1  level, sampled per cycle: begin a run (clears counters).
REQ-007 stop_i  input  1  level, sampled per cycle: end the current run.
REQ-008 br_instr_i  input  1  core EX/MEM stage holds a branch/jump this cycle.
REQ-009 br_miss_i  input  1  core flush due to branch mispredict this cycle.
REQ-010 instr_i  input  32  core IF-stage instruction this cycle.
REQ-011 rd_en_i  input  1  readout request.
REQ-012 rd_addr_i  input  2  counter select: 0 cycles, 1 instructions, 2 branches, 3 misses.
REQ-013 rd_data_o  output  CNT_W  selected counter value, registered.
REQ-014 rd_vld_o  output  1  one-cycle pulse qualifying rd_data_o.
REQ-015 busy_o  output  1  high while in RUN.
REQ-016 done_o  output  1  high while in DONE.
REQ-017 sat_o  output  1  sticky: some counter saturated during the current/last run.

Function
REQ-018 FSM states IDLE, RUN, DONE; state and all counters are registers.
REQ-019 IDLE: start_i=1 -> clear all four counters and sat_o at that edge, go RUN; stop_i ignored.
REQ-020 RUN: each cycle, cycle counter +1; instruction counter +1 if instr_i != 32'h0000_0013 (NOP/bubble); branch counter +1 if br_instr_i; miss counter +1 if br_miss_i.
REQ-021 RUN exit to DONE at the edge ending a cycle where any of: stop_i=1; instr_i == HALT_INSN; WINDOW!=0 and cycle counter == WINDOW-1.
REQ-022 Events of the exiting cycle are counted (that cycle is the last counted cycle); simultaneous exit conditions cause a single transition.
REQ-023 RUN: start_i ignored (no restart mid-run).
REQ-024 DONE: counters hold; start_i=1 -> clear counters and sat_o, go RUN; stop_i ignored.
REQ-025 Counters saturate at all-ones (no wrap); an increment attempted at all-ones sets sat_o, which holds until next start or reset.
REQ-026 Readout accepted in every state: rd_en_i=1 at edge N -> rd_data_o = selected counter value as of before edge N, rd_vld_o=1 during cycle N+1 only.
REQ-027 Back-to-back reads: rd_en_i held high yields rd_vld_o every cycle, one result per request, in order.
REQ-028 rd_data_o holds its last value when rd_vld_o=0.
REQ-029 busy_o, done_o decoded from current state (combinational off state register), never both high.

Reset
REQ-030 rst_i=1 forces immediately, independent of clk_i: state IDLE, all counters 0, rd_data_o 0, rd_vld_o 0, sat_o 0, busy_o 0, done_o 0.
REQ-031 Reset asserted mid-RUN discards the run; after deassertion block stays IDLE until start_i.
REQ-032 Inputs other than rst_i are ignored while rst_i=1.

Verification
REQ-033 Basic run: start_i 1 cycle, then 10 cycles with 7 non-NOP instr, 3 br_instr_i, 1 br_miss_i, stop_i on 10th -> DONE; reads give 10, 7, 3, 1.
REQ-034 Halt detect: instr_i=32'h0000_006F in 5th RUN cycle, no stop_i -> DONE after 5 cycles; cycle count 5, halt instruction counted.
REQ-035 Window: WINDOW=4, start, no stop -> busy_o high exactly 4 cycles, cycle count 4, done_o then high.
REQ-036 Saturation: CNT_W=4, br_instr_i high 20 RUN cycles -> branch count 15, sat_o=1; next start clears both.
REQ-037 Reset mid-run: rst_i pulsed asynchronously in 3rd RUN cycle -> outputs 0 before next edge, IDLE, all reads return 0.
REQ-038 Read/update collision: rd_en_i with rd_addr_i=0 in RUN cycle with count 6 -> rd_data_o=6, rd_vld_o pulses one cycle; start_i during RUN has no effect.
